branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Direct-mapped branch target buffer with 2-bit saturating counters; sits upstream of program_counter.
//  Looks up the fetch PC each cycle and drives take_branch / branch_predict to the PC stage.
//  Trains from branch outcomes resolved in execute; counts resolved branches and mispredicts.
// PARAMETERS
//  ADDR_WIDTH  16  instruction address width (`ADDR_WIDTH)
//  ENTRIES     16  table entries, power of two, >=2
//  IDX_BITS    4   log2(ENTRIES); index = pc[IDX_BITS:1] (halfword-aligned PCs)
//  TAG_BITS    ADDR_WIDTH-IDX_BITS-1  tag = pc[ADDR_WIDTH-1:IDX_BITS+1]
// PORTS
//  clk              in   1           clock, rising edge
//  reset            in   1           asynchronous, active-low
//  lookup_pc        in   ADDR_WIDTH  current fetch PC
//  take_branch      out  1           predict taken (hit && ctr[1])
//  branch_predict   out  ADDR_WIDTH  predicted target (0 on miss)
//  predict_hit      out  1           valid entry with matching tag
//  update_valid     in   1           one-cycle pulse: a branch resolved this cycle
//  update_pc        in   ADDR_WIDTH  PC of resolved branch
//  update_taken     in   1           actual outcome
//  update_target    in   ADDR_WIDTH  actual target (meaningful when taken)
//  update_mispredict in  1           prediction was wrong (qualified by update_valid)
//  branch_count     out  32          resolved branches since reset
//  mispredict_count out  32          mispredicts since reset
// BEHAVIOUR
//  Reset (async assert, sync release): all valid=0, tags/targets=0, ctr=2'b01; both counts=0;
//   so take_branch=0, branch_predict=0, predict_hit=0 immediately.
//  Lookup: combinational from registered table, zero latency; reads pre-update state
//   (same-index update this cycle visible on the next cycle only; no bypass).
//  Update (posedge, update_valid=1), entry e = table[update_pc index]:
//   hit (valid && tag match): ctr sat-inc if taken (max 2'b11), sat-dec if not (min 2'b00);
//    target <= update_target only when taken.
//   miss, taken: allocate/replace: valid=1, tag, target, ctr=2'b10 (weakly taken).
//   miss, not taken: no change (no allocation on not-taken).
//  Counters: branch_count += 1 per update_valid; mispredict_count += 1 when
//   update_valid && update_mispredict; both wrap 2^32-1 -> 0; update_mispredict ignored
//   without update_valid.
//  stall/flush of PC stage have no effect here; training is never dropped.
//  Reset mid-operation: asserting reset clears state in the same instant regardless of
//   a pending update; update on the release edge is applied normally.
//  Aliasing: different PCs sharing an index with different tags evict each other; accepted.
// STRUCTURE
//  defines.vh gains: `BP_ENTRIES, `BP_IDX_BITS, `BP_CTR_WNT (2'b01), `BP_CTR_WT (2'b10).
//  Sub-module sat_counter2: 2-bit next-state function (cur, taken -> next), instanced once
//   on the update path. Table as per-field reg arrays (valid, tag, target, ctr).
// TESTING
//  1 After reset: any lookup_pc -> take_branch=0, predict_hit=0, branch_predict=0, counts=0.
//  2 Update pc=0x0010 taken target=0x0040; next cycle lookup 0x0010 -> hit, taken, 0x0040.
//  3 Two not-taken updates on 0x0010 (ctr 10->01->00): take_branch=0, hit=1; one taken
//    -> ctr 01, still not taken; second taken -> 10, take_branch=1.
//  4 Alias: 0x0010 allocated, then taken update 0x0030 (same index, ENTRIES=16) ->
//    lookup 0x0010 misses, 0x0030 hits target as supplied; not-taken miss on 0x0050 allocates nothing.
//  5 Same-cycle lookup and update on 0x0010: lookup shows old state, new state next cycle;
//    10 updates with 3 mispredict -> branch_count=10, mispredict_count=3.
//  6 Assert reset mid-run with update_valid=1: table and counts clear asynchronously,
//    outputs 0 before next clk edge.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared sizes and counter encodings for the branch predictor
package branch_predictor_pkg;

  localparam int BP_ADDR_WIDTH = 16;
  localparam int BP_ENTRIES    = 16;
  localparam int BP_IDX_BITS   = 4;

  localparam logic [1:0] BP_CTR_SNT = 2'b00;
  localparam logic [1:0] BP_CTR_WNT = 2'b01;
  localparam logic [1:0] BP_CTR_WT  = 2'b10;
  localparam logic [1:0] BP_CTR_ST  = 2'b11;

endpackage

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - 2-bit saturating counter next-state function
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cur_i,
  input  logic       taken_i,
  output logic [1:0] next_o
);

  always_comb begin
    next_o = cur_i;
    if (taken_i) begin
      if (cur_i != BP_CTR_ST) next_o = cur_i + 2'd1;
    end else begin
      if (cur_i != BP_CTR_SNT) next_o = cur_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters and resolve statistics
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ADDR_WIDTH = BP_ADDR_WIDTH,
  parameter int ENTRIES    = BP_ENTRIES,
  parameter int IDX_BITS   = BP_IDX_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] lookup_pc,
  output logic                  take_branch,
  output logic [ADDR_WIDTH-1:0] branch_predict,
  output logic                  predict_hit,
  input  logic                  update_valid,
  input  logic [ADDR_WIDTH-1:0] update_pc,
  input  logic                  update_taken,
  input  logic [ADDR_WIDTH-1:0] update_target,
  input  logic                  update_mispredict,
  output logic [31:0]           branch_count,
  output logic [31:0]           mispredict_count
);

  localparam int TAG_BITS = ADDR_WIDTH - IDX_BITS - 1;

  logic                  valid_q  [ENTRIES];
  logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
  logic [1:0]            ctr_q    [ENTRIES];

  logic [31:0] branch_count_q, branch_count_d;
  logic [31:0] mispredict_count_q, mispredict_count_d;

  logic [IDX_BITS-1:0] lk_idx, up_idx;
  logic [TAG_BITS-1:0] lk_tag, up_tag;
  logic                up_hit;
  logic [1:0]          up_ctr_next;
  logic                unused_pc_lsb;

  // PCs are halfword aligned, so bit 0 never selects anything
  assign unused_pc_lsb = lookup_pc[0] ^ update_pc[0];

  assign lk_idx = lookup_pc[IDX_BITS:1];
  assign lk_tag = lookup_pc[ADDR_WIDTH-1:IDX_BITS+1];
  assign up_idx = update_pc[IDX_BITS:1];
  assign up_tag = update_pc[ADDR_WIDTH-1:IDX_BITS+1];

  // Lookup reads registered state only: an update this cycle shows up next cycle
  assign predict_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign take_branch    = predict_hit && ctr_q[lk_idx][1];
  assign branch_predict = predict_hit ? target_q[lk_idx] : '0;

  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  sat_counter2 u_sat_counter2 (
    .cur_i   (ctr_q[up_idx]),
    .taken_i (update_taken),
    .next_o  (up_ctr_next)
  );

  assign branch_count_d     = branch_count_q + 32'(update_valid);
  assign mispredict_count_d = mispredict_count_q + 32'(update_valid && update_mispredict);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= BP_CTR_WNT;
      end
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
      if (update_valid) begin
        if (up_hit) begin
          ctr_q[up_idx] <= up_ctr_next;
          if (update_taken) target_q[up_idx] <= update_target;
        end else if (update_taken) begin
          // Miss on a taken branch replaces whatever aliased entry lives here
          valid_q[up_idx]  <= 1'b1;
          tag_q[up_idx]    <= up_tag;
          target_q[up_idx] <= update_target;
          ctr_q[up_idx]    <= BP_CTR_WT;
        end
      end
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - randomized self-checking bench with behavioural BTB model
module tb_branch_predictor;

  localparam int ENT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] lookup_pc;
  logic        take_branch;
  logic [15:0] branch_predict;
  logic        predict_hit;
  logic        update_valid;
  logic [15:0] update_pc;
  logic        update_taken;
  logic [15:0] update_target;
  logic        update_mispredict;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int n_checks = 0;
  int n_errors = 0;

  bit          m_valid  [ENT];
  int          m_tag    [ENT];
  int          m_target [ENT];
  int          m_ctr    [ENT];
  int unsigned m_bc, m_mc;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk               (clk),
    .reset             (reset),
    .lookup_pc         (lookup_pc),
    .take_branch       (take_branch),
    .branch_predict    (branch_predict),
    .predict_hit       (predict_hit),
    .update_valid      (update_valid),
    .update_pc         (update_pc),
    .update_taken      (update_taken),
    .update_target     (update_target),
    .update_mispredict (update_mispredict),
    .branch_count      (branch_count),
    .mispredict_count  (mispredict_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
    end
    m_bc = 0; m_mc = 0;
  endfunction

  function automatic void m_lookup(input int pc, output bit hit, output bit tk, output int tgt);
    int idx = (pc / 2) % ENT;
    int tg  = pc / (2 * ENT);
    hit = m_valid[idx] && (m_tag[idx] == tg);
    tk  = hit && (m_ctr[idx] >= 2);
    tgt = hit ? m_target[idx] : 0;
  endfunction

  function automatic void m_update(input int pc, input bit tk, input int tgt, input bit mis);
    int idx = (pc / 2) % ENT;
    int tg  = pc / (2 * ENT);
    m_bc++;
    if (mis) m_mc++;
    if (m_valid[idx] && m_tag[idx] == tg) begin
      m_ctr[idx] = tk ? ((m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3)
                      : ((m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0);
      if (tk) m_target[idx] = tgt;
    end else if (tk) begin
      m_valid[idx] = 1'b1; m_tag[idx] = tg; m_target[idx] = tgt; m_ctr[idx] = 2;
    end
  endfunction

  task automatic look(input string tag, input logic [15:0] pc);
    bit hit, tk;
    int tgt;
    lookup_pc = pc;
    #1;
    m_lookup(int'(pc), hit, tk, tgt);
    check({tag, "_hit"}, 32'(predict_hit), 32'(hit));
    check({tag, "_take"}, 32'(take_branch), 32'(tk));
    check({tag, "_tgt"}, 32'(branch_predict), 32'(tgt));
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_bc"}, branch_count, m_bc);
    check({tag, "_mc"}, mispredict_count, m_mc);
  endtask

  task automatic drive(input logic v, input logic [15:0] pc, input logic tk,
                       input logic [15:0] tgt, input logic mis);
    update_valid = v; update_pc = pc; update_taken = tk;
    update_target = tgt; update_mispredict = mis;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset && update_valid)
      m_update(int'(update_pc), update_taken, int'(update_target), update_mispredict);
    #1;
    update_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    lookup_pc = 16'h0010;
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    m_reset();
    #2;
    check("rst_hit", 32'(predict_hit), 32'd0);
    check("rst_take", 32'(take_branch), 32'd0);
    check("rst_tgt", 32'(branch_predict), 32'd0);
    check_counts("rst");
    @(negedge clk);
    reset = 1'b1;
    tick();

    drive(1'b1, 16'h0010, 1'b1, 16'h0040, 1'b1);
    tick();
    look("alloc", 16'h0010);
    check("alloc_tgt_abs", 32'(branch_predict), 32'h0040);
    check("alloc_take_abs", 32'(take_branch), 32'd1);

    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 16'h0010, 1'b0, 16'h0000, 1'b1);
      tick();
      look("nt_dec", 16'h0010);
    end
    check("nt_take_abs", 32'(take_branch), 32'd0);
    check("nt_hit_abs", 32'(predict_hit), 32'd1);
    drive(1'b1, 16'h0010, 1'b1, 16'h0040, 1'b0);
    tick();
    look("tk_inc1", 16'h0010);
    check("tk_inc1_abs", 32'(take_branch), 32'd0);
    drive(1'b1, 16'h0010, 1'b1, 16'h0040, 1'b0);
    tick();
    look("tk_inc2", 16'h0010);
    check("tk_inc2_abs", 32'(take_branch), 32'd1);

    drive(1'b1, 16'h0030, 1'b1, 16'h0123, 1'b1);
    tick();
    look("alias_old", 16'h0010);
    check("alias_old_abs", 32'(predict_hit), 32'd0);
    look("alias_new", 16'h0030);
    check("alias_new_abs", 32'(branch_predict), 32'h0123);
    drive(1'b1, 16'h0050, 1'b0, 16'h0000, 1'b0);
    tick();
    look("nt_noalloc", 16'h0050);
    look("nt_keep", 16'h0030);

    drive(1'b1, 16'h0010, 1'b1, 16'h0200, 1'b1);
    look("same_pre", 16'h0010);
    check("same_pre_abs", 32'(predict_hit), 32'd0);
    tick();
    look("same_post", 16'h0010);
    check("same_post_abs", 32'(branch_predict), 32'h0200);
    check_counts("directed");

    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 16'($urandom_range(0, 63) * 2), 1'($urandom),
            16'($urandom), 1'($urandom));
      look("rnd", 16'($urandom_range(0, 63) * 2));
      check_counts("rnd");
      tick();
    end

    drive(1'b1, 16'h0010, 1'b1, 16'h0040, 1'b1);
    #3;
    reset = 1'b0;
    #1;
    m_reset();
    look("arst", 16'h0010);
    check_counts("arst");
    tick();
    look("arst_hold", 16'h0010);
    reset = 1'b1;
    drive(1'b1, 16'h0010, 1'b1, 16'h0044, 1'b0);
    tick();
    look("release_upd", 16'h0010);
    check_counts("release_upd");

    m_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 16'($urandom_range(0, 63) * 2), 1'($urandom), 16'($urandom), 1'(i % 4 == 1));
      tick();
    end
    check_counts("ten");
    check("ten_bc_abs", branch_count, 32'd10);
    check("ten_mc_abs", mispredict_count, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
